// File: rtl/fix_exec_report_decoder_if.sv
// Byte-stream input and execution-event output bundle of the FIX execution-report decoder.
// master = byte source / event consumer side, slave = decoder side.
interface fix_exec_report_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        exec_valid;
    logic        exec_ready;
    logic [1:0]  exec_type;
    logic [31:0] exec_qty;
    logic [31:0] exec_price;
    logic [7:0]  exec_side;

    modport master (
        output rx_data, rx_valid, exec_ready,
        input  rx_ready, exec_valid, exec_type, exec_qty, exec_price, exec_side
    );

    modport slave (
        input  rx_data, rx_valid, exec_ready,
        output rx_ready, exec_valid, exec_type, exec_qty, exec_price, exec_side
    );
endinterface

// File: rtl/fix_exec_report_decoder.sv
// Parses an inbound FIX tag=value/SOH stream and emits one event per good ExecutionReport (35=8).
// Define FIX_CHECKSUM_EN to verify the tag 10 checksum; otherwise tag 10 is only format-checked.
module fix_exec_report_decoder #(
    parameter int MAX_DIGITS = 10,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    fix_exec_report_decoder_if.slave  bus,
    output logic [CNT_W-1:0]          msg_count,
    output logic [CNT_W-1:0]          error_count,
    output logic [1:0]                parser_state
);

    localparam int LEN_W = $clog2(MAX_DIGITS + 2);
    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EQ  = 8'h3D;
    localparam logic [7:0] CH1 = 8'h31;
    localparam logic [7:0] CH2 = 8'h32;
    localparam logic [7:0] CH8 = 8'h38;

    typedef enum logic [1:0] {ST_TAG = 2'd0, ST_VALUE = 2'd1, ST_EMIT = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [15:0]         tag_q, tag_d;
    logic                tag_nd_q, tag_nd_d;
    logic                tag_unk_q, tag_unk_d;
    logic [31:0]         val_q, val_d;
    logic [LEN_W-1:0]    vlen_q, vlen_d;
    logic                val_bad_q, val_bad_d;
    logic [7:0]          char_q, char_d;
    logic                msg_err_q, msg_err_d;
    logic                has35_q, has35_d, has39_q, has39_d, has54_q, has54_d;
    logic                has31_q, has31_d, has32_q, has32_d;
    logic [7:0]          mtype_q, mtype_d, ord_q, ord_d, side_q, side_d;
    logic [31:0]         qty_q, qty_d, px_q, px_d;
    logic                exec_valid_q, exec_valid_d;
    logic [1:0]          exec_type_q, exec_type_d;
    logic [31:0]         exec_qty_q, exec_qty_d, exec_price_q, exec_price_d;
    logic [7:0]          exec_side_q, exec_side_d;
    logic [CNT_W-1:0]    msg_count_q, msg_count_d, error_count_q, error_count_d;
`ifdef FIX_CHECKSUM_EN
    logic [7:0]          cks_q, cks_d, cks_at_q, cks_at_d;
`endif

    logic        byte_ok, is_digit, num_ok, chr_ok, ck_ok, rpt_ok;
    logic [3:0]  dig;
    logic [35:0] val_wide;

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        tag_nd_d      = tag_nd_q;
        tag_unk_d     = tag_unk_q;
        val_d         = val_q;
        vlen_d        = vlen_q;
        val_bad_d     = val_bad_q;
        char_d        = char_q;
        msg_err_d     = msg_err_q;
        has35_d       = has35_q;
        has39_d       = has39_q;
        has54_d       = has54_q;
        has31_d       = has31_q;
        has32_d       = has32_q;
        mtype_d       = mtype_q;
        ord_d         = ord_q;
        side_d        = side_q;
        qty_d         = qty_q;
        px_d          = px_q;
        exec_valid_d  = exec_valid_q;
        exec_type_d   = exec_type_q;
        exec_qty_d    = exec_qty_q;
        exec_price_d  = exec_price_q;
        exec_side_d   = exec_side_q;
        msg_count_d   = msg_count_q;
        error_count_d = error_count_q;
`ifdef FIX_CHECKSUM_EN
        cks_d         = cks_q;
        cks_at_d      = cks_at_q;
`endif

        byte_ok  = bus.rx_valid && (state_q != ST_EMIT);
        is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        dig      = bus.rx_data[3:0];
        val_wide = {4'b0, val_q} * 36'd10 + {32'b0, dig};
        num_ok   = !val_bad_q && (vlen_q != '0) && (vlen_q <= LEN_W'(MAX_DIGITS));
        chr_ok   = (vlen_q == LEN_W'(1));
`ifdef FIX_CHECKSUM_EN
        ck_ok    = num_ok && (vlen_q == LEN_W'(3)) && (val_q == {24'b0, cks_at_q});
`else
        ck_ok    = num_ok;
`endif
        rpt_ok   = has39_q && has54_q &&
                   ((ord_q == CH1) || (ord_q == CH2) || (ord_q == CH8)) &&
                   ((side_q == CH1) || (side_q == CH2)) &&
                   ((ord_q == CH8) || (has31_q && has32_q));

        unique case (state_q)
            ST_TAG: if (byte_ok) begin
`ifdef FIX_CHECKSUM_EN
                cks_d = cks_q + bus.rx_data;
                // Sum through the SOH before "10=": drop the '1','0','=' bytes again.
                if (bus.rx_data == EQ && tag_q == 16'd10 && !tag_unk_q)
                    cks_at_d = cks_q + bus.rx_data - 8'h9E;
`endif
                if (bus.rx_data == EQ) begin
                    if (!tag_nd_q) begin
                        msg_err_d = 1'b1;
                        tag_unk_d = 1'b1;
                    end
                    val_d     = '0;
                    vlen_d    = '0;
                    val_bad_d = 1'b0;
                    state_d   = ST_VALUE;
                end else if (is_digit) begin
                    tag_nd_d = 1'b1;
                    if (tag_q < 16'd1000) tag_d = tag_q * 16'd10 + {12'b0, dig};
                    else                  tag_unk_d = 1'b1;
                end else begin
                    msg_err_d = 1'b1;
                    tag_unk_d = 1'b1;
                end
            end
            ST_VALUE: if (byte_ok) begin
`ifdef FIX_CHECKSUM_EN
                cks_d = cks_q + bus.rx_data;
`endif
                if (bus.rx_data == SOH) begin
                    tag_d     = '0;
                    tag_nd_d  = 1'b0;
                    tag_unk_d = 1'b0;
                    state_d   = ST_TAG;
                    if (!tag_unk_q) begin
                        unique case (tag_q)
                            16'd35: if (chr_ok) begin mtype_d = char_q; has35_d = 1'b1; end else msg_err_d = 1'b1;
                            16'd39: if (chr_ok) begin ord_d   = char_q; has39_d = 1'b1; end else msg_err_d = 1'b1;
                            16'd54: if (chr_ok) begin side_d  = char_q; has54_d = 1'b1; end else msg_err_d = 1'b1;
                            16'd32: if (num_ok) begin qty_d   = val_q;  has32_d = 1'b1; end else msg_err_d = 1'b1;
                            16'd31: if (num_ok) begin px_d    = val_q;  has31_d = 1'b1; end else msg_err_d = 1'b1;
                            16'd10: begin
                                if (msg_err_q || !ck_ok || !has35_q) begin
                                    error_count_d = error_count_q + 1'b1;
                                end else if (mtype_q == CH8) begin
                                    if (rpt_ok) begin
                                        exec_valid_d = 1'b1;
                                        exec_type_d  = (ord_q == CH1) ? 2'd1 : (ord_q == CH2) ? 2'd2 : 2'd3;
                                        exec_qty_d   = qty_q;
                                        exec_price_d = px_q;
                                        exec_side_d  = side_q;
                                        msg_count_d  = msg_count_q + 1'b1;
                                        state_d      = ST_EMIT;
                                    end else begin
                                        error_count_d = error_count_q + 1'b1;
                                    end
                                end
                                // Message closed: forget everything learned about it.
                                msg_err_d = 1'b0;
                                has35_d   = 1'b0;
                                has39_d   = 1'b0;
                                has54_d   = 1'b0;
                                has31_d   = 1'b0;
                                has32_d   = 1'b0;
                                mtype_d   = '0;
                                ord_d     = '0;
                                side_d    = '0;
                                qty_d     = '0;
                                px_d      = '0;
`ifdef FIX_CHECKSUM_EN
                                cks_d     = '0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    if (vlen_q == '0) char_d = bus.rx_data;
                    if (vlen_q <= LEN_W'(MAX_DIGITS)) vlen_d = vlen_q + LEN_W'(1);
                    if (is_digit) begin
                        val_d = val_wide[31:0];
                        if (val_wide[35:32] != 4'd0) val_bad_d = 1'b1;
                    end else begin
                        val_bad_d = 1'b1;
                    end
                end
            end
            ST_EMIT: if (bus.exec_ready) begin
                exec_valid_d = 1'b0;
                state_d      = ST_TAG;
            end
            default: state_d = ST_TAG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_TAG;
            tag_q         <= '0;
            tag_nd_q      <= 1'b0;
            tag_unk_q     <= 1'b0;
            val_q         <= '0;
            vlen_q        <= '0;
            val_bad_q     <= 1'b0;
            char_q        <= '0;
            msg_err_q     <= 1'b0;
            has35_q       <= 1'b0;
            has39_q       <= 1'b0;
            has54_q       <= 1'b0;
            has31_q       <= 1'b0;
            has32_q       <= 1'b0;
            mtype_q       <= '0;
            ord_q         <= '0;
            side_q        <= '0;
            qty_q         <= '0;
            px_q          <= '0;
            exec_valid_q  <= 1'b0;
            exec_type_q   <= '0;
            exec_qty_q    <= '0;
            exec_price_q  <= '0;
            exec_side_q   <= '0;
            msg_count_q   <= '0;
            error_count_q <= '0;
`ifdef FIX_CHECKSUM_EN
            cks_q         <= '0;
            cks_at_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            tag_nd_q      <= tag_nd_d;
            tag_unk_q     <= tag_unk_d;
            val_q         <= val_d;
            vlen_q        <= vlen_d;
            val_bad_q     <= val_bad_d;
            char_q        <= char_d;
            msg_err_q     <= msg_err_d;
            has35_q       <= has35_d;
            has39_q       <= has39_d;
            has54_q       <= has54_d;
            has31_q       <= has31_d;
            has32_q       <= has32_d;
            mtype_q       <= mtype_d;
            ord_q         <= ord_d;
            side_q        <= side_d;
            qty_q         <= qty_d;
            px_q          <= px_d;
            exec_valid_q  <= exec_valid_d;
            exec_type_q   <= exec_type_d;
            exec_qty_q    <= exec_qty_d;
            exec_price_q  <= exec_price_d;
            exec_side_q   <= exec_side_d;
            msg_count_q   <= msg_count_d;
            error_count_q <= error_count_d;
`ifdef FIX_CHECKSUM_EN
            cks_q         <= cks_d;
            cks_at_q      <= cks_at_d;
`endif
        end
    end

    assign bus.rx_ready   = (state_q != ST_EMIT);
    assign bus.exec_valid = exec_valid_q;
    assign bus.exec_type  = exec_type_q;
    assign bus.exec_qty   = exec_qty_q;
    assign bus.exec_price = exec_price_q;
    assign bus.exec_side  = exec_side_q;
    assign msg_count      = msg_count_q;
    assign error_count    = error_count_q;
    assign parser_state   = state_q;

endmodule

// File: tb/tb_fix_exec_report_decoder.sv
// Scoreboard bench for fix_exec_report_decoder: expected events queued per message, popped on handshake.
module tb_fix_exec_report_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] msg_count, error_count;
    logic [1:0]  parser_state;

    fix_exec_report_decoder_if bus ();

    fix_exec_report_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .msg_count    (msg_count),
        .error_count  (error_count),
        .parser_state (parser_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] q;
        logic [31:0] p;
        logic [7:0]  s;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_msg = 0;
    int  exp_err = 0;

    // Handshake seen at negedge completes at the following posedge.
    always @(negedge clk) begin
        if (!rst && bus.exec_valid && bus.exec_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event got type=%0d qty=%0d px=%0d side=%0d required none",
                         bus.exec_type, bus.exec_qty, bus.exec_price, bus.exec_side);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if ({bus.exec_type, bus.exec_qty, bus.exec_price, bus.exec_side} !== {e.t, e.q, e.p, e.s}) begin
                    n_bad++;
                    $display("FAIL event got type=%0d qty=%0d px=%0d side=%0d required type=%0d qty=%0d px=%0d side=%0d",
                             bus.exec_type, bus.exec_qty, bus.exec_price, bus.exec_side, e.t, e.q, e.p, e.s);
                end
            end
        end
    end

    function automatic string mk(input string body, input int adj);
        int sum = 0;
        for (int i = 0; i < body.len(); i++) begin
            byte c;
            c = body[i];
            sum += (c == 8'h7C) ? 1 : int'(c);
        end
        return $sformatf("%s10=%03d|", body, (sum + adj) % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!bus.rx_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_stall got rx_ready=0 for %0d cycles required 1", w);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_msg(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            send_byte((c == 8'h7C) ? 8'h01 : c);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [31:0] q, input logic [31:0] p, input logic [7:0] s);
        ev_t e;
        e.t = t; e.q = q; e.p = p; e.s = s;
        sb.push_back(e);
    endtask

    task automatic settle_and_check(input string name);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (msg_count !== 32'(exp_msg)) begin
            n_bad++;
            $display("FAIL %s msg_count got %0d required %0d", name, msg_count, exp_msg);
        end
        n_cmp++;
        if (error_count !== 32'(exp_err)) begin
            n_bad++;
            $display("FAIL %s error_count got %0d required %0d", name, error_count, exp_err);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s pending_events got %0d required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.exec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.exec_valid, bus.rx_ready, parser_state} !== {1'b0, 1'b1, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_ctrl got valid=%0d ready=%0d state=%0d required 0 1 0",
                     bus.exec_valid, bus.rx_ready, parser_state);
        end
        n_cmp++;
        if ({bus.exec_type, bus.exec_qty, bus.exec_price, bus.exec_side, msg_count, error_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got type=%0d qty=%0d px=%0d side=%0d msgs=%0d errs=%0d required all 0",
                     bus.exec_type, bus.exec_qty, bus.exec_price, bus.exec_side, msg_count, error_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        push(2'd2, 32'd100, 32'd50025, 8'h31);
        send_msg(mk("35=8|39=2|54=1|32=100|31=50025|", 0));
        exp_msg++;
        settle_and_check("fill");
    endtask

    task automatic test_reject();
        push(2'd3, 32'd0, 32'd0, 8'h32);
        send_msg(mk("35=8|39=8|54=2|", 0));
        exp_msg++;
        settle_and_check("reject");
    endtask

    task automatic test_heartbeat_resync();
        send_msg(mk("35=0|", 0));
        settle_and_check("heartbeat");
        push(2'd1, 32'd7, 32'd123, 8'h32);
        send_msg(mk("35=8|39=1|54=2|32=7|31=123|", 0));
        exp_msg++;
        settle_and_check("resync");
    endtask

    task automatic test_numeric_bounds();
        send_msg(mk("35=8|39=2|54=1|32=99999999999|31=5|", 0));
        exp_err++;
        send_msg(mk("35=8|39=2|54=1|32=4294967296|31=5|", 0));
        exp_err++;
        settle_and_check("qty_overflow");
        push(2'd1, 32'hFFFF_FFFF, 32'd1, 8'h31);
        send_msg(mk("35=8|39=1|54=1|32=4294967295|31=1|", 0));
        exp_msg++;
        settle_and_check("qty_max");
    endtask

    task automatic test_bad_fields();
        send_msg(mk("35=8|39=2|54=3|32=1|31=1|", 0));
        send_msg(mk("35=8|39=1|54=1|32=1|", 0));
        send_msg(mk("39=2|54=1|32=1|31=1|", 0));
        send_msg(mk("35=8|39=22|54=1|32=1|31=1|", 0));
        exp_err += 4;
        push(2'd2, 32'd9, 32'd3, 8'h31);
        send_msg(mk("35=8|39=1|39=2|54=1|32=5|32=9|31=3|", 0));
        exp_msg++;
        settle_and_check("bad_fields");
    endtask

    task automatic test_backpressure();
        string m2;
        bit    stable = 1'b1;
        bus.exec_ready = 1'b0;
        push(2'd2, 32'd42, 32'd777, 8'h32);
        send_msg(mk("35=8|39=2|54=2|32=42|31=777|", 0));
        exp_msg++;
        m2 = mk("35=8|39=1|54=1|32=5|31=6|", 0);
        bus.rx_data  = 8'h33;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(bus.exec_valid === 1'b1 && bus.rx_ready === 1'b0 && bus.exec_type === 2'd2 &&
                  bus.exec_qty === 32'd42 && bus.exec_price === 32'd777 && bus.exec_side === 8'h32))
                stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL stall_hold got unstable valid/ready/outputs required held for 20 cycles");
        end
        @(posedge clk);
        #1;
        bus.exec_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.exec_valid, bus.rx_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL release got valid=%0d ready=%0d required 0 1", bus.exec_valid, bus.rx_ready);
        end
        push(2'd1, 32'd5, 32'd6, 8'h31);
        send_msg(m2);
        exp_msg++;
        settle_and_check("backpressure");
    endtask

    task automatic test_reset_mid_msg();
        send_msg("35=8|39=2|");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_msg = 0;
        exp_err = 0;
        push(2'd2, 32'd10, 32'd20, 8'h31);
        send_msg(mk("35=8|39=2|54=1|32=10|31=20|", 0));
        exp_msg++;
        settle_and_check("reset_mid");
    endtask

    task automatic test_checksum();
`ifdef FIX_CHECKSUM_EN
        send_msg(mk("35=8|39=2|54=1|32=100|31=50025|", 1));
        exp_err++;
        settle_and_check("bad_checksum");
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_reject();
        test_heartbeat_resync();
        test_numeric_bounds();
        test_bad_fields();
        test_backpressure();
        test_reset_mid_msg();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fix_exec_report_decoder.md
Name: fix_exec_report_decoder

Overview:
Receive-side counterpart of the order path's FIX encoder. Parses an inbound FIX byte stream of tag=value fields separated by SOH (0x01) and extracts ExecutionReport (35=8) messages. Each good report is presented as one fill/partial/reject event to the order manager / position tracker over a valid/ready handshake. Malformed messages are dropped and counted.

Parameters:
MAX_DIGITS, 10, max decimal digits accepted in a numeric value (qty, price); more is an error.
CNT_W, 32, width of msg_count and error_count.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  inbound FIX byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  byte accepted when rx_valid && rx_ready; rx_ready = !exec_valid
exec_valid  output  1  event available; held until exec_ready
exec_ready  input  1  consumer accepts event
exec_type  output  2  1=partial (39=1), 2=filled (39=2), 3=rejected (39=8)
exec_qty  output  32  LastQty (tag 32), unsigned integer
exec_price  output  32  LastPx (tag 31), integer ticks, digits only
exec_side  output  8  1=buy, 2=sell (tag 54), same encoding as trade_side
msg_count  output  CNT_W  good reports emitted
error_count  output  CNT_W  messages dropped as malformed
parser_state  output  2  current FSM state for debug

Behaviour:
- Reset (rst=1 at clk edge): FSM to TAG, all accumulators/flags cleared, exec_valid=0, exec_type/qty/price/side=0, both counters=0. Reset mid-message discards the partial message without counting it.
- FSM states:
  - TAG: digits accumulate tag number; '=' goes to VALUE. A non-digit, or '=' with no digits, sets msg_err and the tag is treated as unknown.
  - VALUE: bytes accumulate into the per-tag register; SOH closes the field and returns to TAG, except after tag 10, which goes to EMIT or back to TAG as below.
  - EMIT: exec_valid=1, rx_ready=0 until exec_ready; then back to TAG.
- Message boundary: starts at the first byte after reset or after a closed tag-10 field. The SOH that closes tag 10 ends the message.
- Numeric values (tags 31, 32, 10):
  - Accumulate as val*10+digit.
  - Non-digit, empty value, more than MAX_DIGITS digits, or value > 2^32-1 sets msg_err.
- Char values (tags 35, 39, 54): exactly one byte required; otherwise msg_err.
- Other tags: value ignored.
- Duplicate tag: last value wins.
- On message end, evaluated in order:
  1. If msg_err: drop, error_count+1.
  2. Else if 35 is absent: drop, error_count+1.
  3. Else if 35 != '8': drop silently, no counter change (heartbeats etc).
  4. Else validate: 39 must be in {'1','2','8'} and 54 in {'1','2'}. For 39 = '1' or '2', tags 32 and 31 must be present. For 39='8', qty/price are output as given or 0 if absent. Any failure: drop, error_count+1.
  5. Else: latch outputs, enter EMIT, msg_count+1 on the same edge.
- Latency: exec_valid rises on the clock edge after the closing SOH byte is accepted.
- Outputs are stable while exec_valid=1. When exec_valid && exec_ready, exec_valid drops next edge and rx_ready rises.
- Counters wrap modulo 2^CNT_W.
- Per-message state (field-present flags, msg_err, checksum) is cleared at every message end, whether emitted, dropped or ignored.

Optional Feature:
FIX_CHECKSUM_EN:
- Defined:
  - Running sum mod 256 covers every byte from message start through the SOH preceding "10=".
  - The sum excludes the "10=" bytes; the implementation subtracts 0x9E.
  - Tag 10 value must be exactly 3 digits and equal that sum; otherwise error_count+1 and drop.
- Undefined: tag 10 value is parsed only for digit format (1 to MAX_DIGITS digits); the sum is not computed or checked.

Test Plan:
1. "35=8|39=2|54=1|32=100|31=50025|10=ccc|" with correct ccc, exec_ready=1 -> one exec_valid pulse with type=2, side=1, qty=100, price=50025; msg_count=1, error_count=0.
2. Same message with 39=8, no 32/31 -> type=3, qty=0, price=0, side as sent, msg_count+1.
3. "35=0|10=ccc|" heartbeat -> no exec_valid, counters unchanged. Then a valid 39=1 report -> emitted normally (resync verified).
4. 32=99999999999 (11 digits), then 32=4294967296 -> each dropped, error_count=2, no exec_valid.
5. exec_ready held 0 for 20 cycles after an emit with rx_valid=1 -> rx_ready=0 and outputs stable throughout. exec_ready=1 -> next edge exec_valid=0, rx_ready=1, no bytes lost.
6. rst=1 mid-message (after "39=2|"), then a complete valid report -> only the second is emitted, msg_count=1. With FIX_CHECKSUM_EN, a wrong checksum (ccc off by 1) -> error_count+1, no emit.
